// File: rtl/sdram_fb_reader_if.sv
// Read-port and pixel-stream bundle for the framebuffer scan-out fetcher.
// master = fetcher side, slave = controller/consumer side.
interface sdram_fb_reader_if #(
  parameter int HADDR_WIDTH = 22
);
  logic [HADDR_WIDTH-1:0] rd_addr;
  logic                   rd_enable;
  logic [15:0]            rd_data;
  logic                   rd_ready;
  logic                   busy;
  logic [15:0]            pix_data;
  logic                   pix_valid;
  logic                   pix_ready;

  modport master (
    output rd_addr, rd_enable,
    output pix_data, pix_valid,
    input  rd_data, rd_ready, busy,
    input  pix_ready
  );

  modport slave (
    input  rd_addr, rd_enable,
    input  pix_data, pix_valid,
    output rd_data, rd_ready, busy,
    output pix_ready
  );
endinterface

// File: rtl/sdram_fb_reader.sv
// Framebuffer scan-out fetcher: sequential single-word SDRAM reads into a show-ahead FIFO.
// Define FB_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module sdram_fb_reader #(
  parameter int HADDR_WIDTH = 22,
  parameter int FIFO_DEPTH  = 16,
  parameter int FB_BASE     = 0,
  parameter int FRAME_WORDS = 307200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic frame_start,
  sdram_fb_reader_if.master bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic frame_done,
  output logic underrun
`ifdef FB_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [HADDR_WIDTH-1:0] BASE =
    HADDR_WIDTH'(FB_BASE);
  localparam logic [HADDR_WIDTH-1:0] LAST =
    HADDR_WIDTH'(FB_BASE + FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state_q, state_d;
  logic [HADDR_WIDTH-1:0] ptr_q;
  logic discard_q;
  logic issue, xfer_done;
  logic push, pop, urun_ev;

  logic [15:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] level_q;
  logic [15:0] last_q;

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    xfer_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && !frame_start && level_q < DEPTH_L) begin
          state_d = REQ;
          issue   = 1'b1;
        end
      end
      REQ: begin
        if (bus.busy) state_d = WAIT;
      end
      WAIT: begin
        if (bus.rd_ready) begin
          state_d   = IDLE;
          xfer_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // a flush drops the in-flight word as well as anything marked for discard
  assign push = xfer_done && !discard_q && !frame_start;
  assign pop = bus.pix_valid && bus.pix_ready && !frame_start;
  assign urun_ev = bus.pix_ready && !bus.pix_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= BASE;
      discard_q     <= 1'b0;
      bus.rd_enable <= 1'b0;
      bus.rd_addr   <= '0;
      frame_done    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus.rd_enable <= (state_d == REQ);
      if (issue) bus.rd_addr <= ptr_q;
      frame_done <= push && (ptr_q == LAST);
      if (frame_start) ptr_q <= BASE;
      else if (push) ptr_q <= (ptr_q == LAST) ? BASE : ptr_q + 1'b1;
      if (xfer_done) discard_q <= 1'b0;
      else if (frame_start && state_q != IDLE) discard_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= bus.rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= '0;
      rd_q     <= '0;
      level_q  <= '0;
      last_q   <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= urun_ev;
      if (pop) last_q <= mem[rd_q];
      if (frame_start) begin
        wr_q    <= '0;
        rd_q    <= '0;
        level_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + 1'b1;
        if (pop) rd_q <= rd_q + 1'b1;
        if (push && !pop) level_q <= level_q + 1'b1;
        else if (pop && !push) level_q <= level_q - 1'b1;
      end
    end
  end

`ifdef FB_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) underrun_cnt <= '0;
    else if (frame_start) underrun_cnt <= '0;
    else if (urun_ev && underrun_cnt != 16'hFFFF)
      underrun_cnt <= underrun_cnt + 1'b1;
  end
`endif

  // the last popped word stays visible while the FIFO is empty
  assign bus.pix_valid = (level_q != '0);
  assign bus.pix_data = bus.pix_valid ? mem[rd_q] : last_q;
  assign fifo_level = level_q;
endmodule

// File: tb/tb_sdram_fb_reader.sv
// Directed bench for sdram_fb_reader: two instances (full frame, 4-word frame)
// each driven by an 8-cycle-latency SDRAM read model with optional refresh stall.
module tb_sdram_fb_reader;
  localparam int LAT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic en_a = 1'b0, fs_a = 1'b0, refresh_a = 1'b0;
  logic en_b = 1'b0, fs_b = 1'b0;
  logic [4:0] lvl_a, lvl_b;
  logic done_a, done_b, urun_a, urun_b;
`ifdef FB_UNDERRUN_CNT_EN
  logic [15:0] ucnt_a, ucnt_b;
`endif

  int n_vec = 0;
  int n_err = 0;

  sdram_fb_reader_if #(.HADDR_WIDTH(22)) bus_a ();
  sdram_fb_reader_if #(.HADDR_WIDTH(22)) bus_b ();

  sdram_fb_reader #(
    .HADDR_WIDTH(22), .FIFO_DEPTH(16),
    .FB_BASE(0), .FRAME_WORDS(307200)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .enable(en_a), .frame_start(fs_a),
    .bus(bus_a),
    .fifo_level(lvl_a), .frame_done(done_a),
    .underrun(urun_a)
`ifdef FB_UNDERRUN_CNT_EN
    , .underrun_cnt(ucnt_a)
`endif
  );

  sdram_fb_reader #(
    .HADDR_WIDTH(22), .FIFO_DEPTH(16),
    .FB_BASE(0), .FRAME_WORDS(4)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .enable(en_b), .frame_start(fs_b),
    .bus(bus_b),
    .fifo_level(lvl_b), .frame_done(done_b),
    .underrun(urun_b)
`ifdef FB_UNDERRUN_CNT_EN
    , .underrun_cnt(ucnt_b)
`endif
  );

  function automatic logic [15:0] memw(input logic [21:0] a);
    return 16'(a * 22'd3) ^ 16'h5A5A;
  endfunction

  int cnt_a, cnt_b;
  logic [21:0] addr_a, addr_b;
  logic [21:0] acc_a [$];
  logic [21:0] acc_b [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_a.busy <= 1'b0;
      bus_a.rd_ready <= 1'b0;
      bus_a.rd_data <= '0;
      cnt_a <= 0;
      addr_a <= '0;
    end else begin
      bus_a.rd_ready <= 1'b0;
      if (cnt_a != 0) begin
        cnt_a <= cnt_a - 1;
        if (cnt_a == 1) begin
          bus_a.rd_ready <= 1'b1;
          bus_a.rd_data <= memw(addr_a);
          bus_a.busy <= 1'b0;
        end
      end else if (bus_a.rd_enable && !bus_a.busy && !refresh_a) begin
        bus_a.busy <= 1'b1;
        cnt_a <= LAT;
        addr_a <= bus_a.rd_addr;
        acc_a.push_back(bus_a.rd_addr);
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_b.busy <= 1'b0;
      bus_b.rd_ready <= 1'b0;
      bus_b.rd_data <= '0;
      cnt_b <= 0;
      addr_b <= '0;
    end else begin
      bus_b.rd_ready <= 1'b0;
      if (cnt_b != 0) begin
        cnt_b <= cnt_b - 1;
        if (cnt_b == 1) begin
          bus_b.rd_ready <= 1'b1;
          bus_b.rd_data <= memw(addr_b);
          bus_b.busy <= 1'b0;
        end
      end else if (bus_b.rd_enable && !bus_b.busy) begin
        bus_b.busy <= 1'b1;
        cnt_b <= LAT;
        addr_b <= bus_b.rd_addr;
        acc_b.push_back(bus_b.rd_addr);
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus_a.rd_enable !== 1'b0 || bus_a.rd_addr !== 22'd0) begin
      n_err++;
      $display("FAIL reset_rd got en=%b addr=%0d want 0/0",
               bus_a.rd_enable, bus_a.rd_addr);
    end
    n_vec++;
    if (bus_a.pix_valid !== 1'b0 || bus_a.pix_data !== 16'd0) begin
      n_err++;
      $display("FAIL reset_pix got v=%b d=%h want 0/0000",
               bus_a.pix_valid, bus_a.pix_data);
    end
    n_vec++;
    if (lvl_a !== 5'd0 || done_a !== 1'b0 || urun_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags got lvl=%0d done=%b urun=%b want 0/0/0",
               lvl_a, done_a, urun_a);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    bit seen_en = 1'b0;
    en_a = 1'b1;
    for (int i = 0; i < 600 && lvl_a != 5'd16; i++) @(negedge clk);
    n_vec++;
    if (lvl_a !== 5'd16) begin
      n_err++;
      $display("FAIL fill_level got %0d want 16", lvl_a);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_a.rd_enable) seen_en = 1'b1;
    end
    n_vec++;
    if (seen_en !== 1'b0) begin
      n_err++;
      $display("FAIL fill_idle got rd_enable=1 want 0");
    end
    n_vec++;
    if (acc_a.size() != 16) begin
      n_err++;
      $display("FAIL fill_reads got %0d want 16", acc_a.size());
    end
    for (int i = 0; i < acc_a.size() && i < 16; i++) begin
      n_vec++;
      if (acc_a[i] !== 22'(i)) begin
        n_err++;
        $display("FAIL fill_addr[%0d] got %0d want %0d", i, acc_a[i], i);
      end
    end
  endtask

  task automatic test_drain();
    en_a = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_vec++;
      if (bus_a.pix_valid !== 1'b1 || bus_a.pix_data !== memw(22'(k))) begin
        n_err++;
        $display("FAIL drain_pix[%0d] got v=%b d=%h want 1/%h",
                 k, bus_a.pix_valid, bus_a.pix_data, memw(22'(k)));
      end
      bus_a.pix_ready = 1'b1;
      @(negedge clk);
    end
    bus_a.pix_ready = 1'b0;
    n_vec++;
    if (lvl_a !== 5'd0 || bus_a.pix_data !== memw(22'd15)) begin
      n_err++;
      $display("FAIL drain_hold got lvl=%0d d=%h want 0/%h",
               lvl_a, bus_a.pix_data, memw(22'd15));
    end
    @(negedge clk);
    n_vec++;
    if (urun_a !== 1'b0) begin
      n_err++;
      $display("FAIL drain_no_urun got %b want 0", urun_a);
    end
  endtask

  task automatic test_refresh();
    int base;
    refresh_a = 1'b1;
    en_a = 1'b1;
    for (int i = 0; i < 50 && !bus_a.rd_enable; i++) @(negedge clk);
    n_vec++;
    if (bus_a.rd_enable !== 1'b1) begin
      n_err++;
      $display("FAIL refresh_req got rd_enable=0 want 1");
    end
    en_a = 1'b0;
    base = acc_a.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus_a.rd_enable !== 1'b1 || bus_a.rd_addr !== 22'd16) begin
        n_err++;
        $display("FAIL refresh_hold[%0d] got en=%b addr=%0d want 1/16",
                 i, bus_a.rd_enable, bus_a.rd_addr);
      end
    end
    refresh_a = 1'b0;
    for (int i = 0; i < 60 && lvl_a != 5'd1; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    n_vec++;
    if (lvl_a !== 5'd1) begin
      n_err++;
      $display("FAIL refresh_level got %0d want 1", lvl_a);
    end
    n_vec++;
    if (acc_a.size() != base + 1) begin
      n_err++;
      $display("FAIL refresh_issue got %0d reads want 1", acc_a.size() - base);
    end else if (acc_a[base] !== 22'd16) begin
      n_err++;
      $display("FAIL refresh_addr got %0d want 16", acc_a[base]);
    end
    n_vec++;
    if (bus_a.pix_data !== memw(22'd16)) begin
      n_err++;
      $display("FAIL refresh_data got %h want %h", bus_a.pix_data, memw(22'd16));
    end
    bus_a.pix_ready = 1'b1;
    @(negedge clk);
    bus_a.pix_ready = 1'b0;
  endtask

  task automatic test_underrun();
    fs_a = 1'b1;
    @(negedge clk);
    fs_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus_a.pix_ready = 1'b1;
      @(negedge clk);
      bus_a.pix_ready = 1'b0;
      n_vec++;
      if (urun_a !== 1'b1 || lvl_a !== 5'd0) begin
        n_err++;
        $display("FAIL urun_pulse[%0d] got u=%b lvl=%0d want 1/0", k, urun_a, lvl_a);
      end
      @(negedge clk);
      n_vec++;
      if (urun_a !== 1'b0) begin
        n_err++;
        $display("FAIL urun_clear[%0d] got %b want 0", k, urun_a);
      end
    end
`ifdef FB_UNDERRUN_CNT_EN
    n_vec++;
    if (ucnt_a !== 16'd3) begin
      n_err++;
      $display("FAIL urun_cnt got %0d want 3", ucnt_a);
    end
    fs_a = 1'b1;
    @(negedge clk);
    fs_a = 1'b0;
    n_vec++;
    if (ucnt_a !== 16'd0) begin
      n_err++;
      $display("FAIL urun_cnt_clr got %0d want 0", ucnt_a);
    end
`endif
  endtask

  task automatic test_frame_start();
    int base;
    en_a = 1'b1;
    for (int i = 0; i < 300 &&
         !(bus_a.busy && !bus_a.rd_enable && bus_a.rd_addr == 22'd5); i++)
      @(negedge clk);
    n_vec++;
    if (!(bus_a.busy && !bus_a.rd_enable && bus_a.rd_addr == 22'd5)) begin
      n_err++;
      $display("FAIL fs_wait got addr=%0d busy=%b want WAIT on addr 5",
               bus_a.rd_addr, bus_a.busy);
    end
    n_vec++;
    if (lvl_a !== 5'd5) begin
      n_err++;
      $display("FAIL fs_pre_level got %0d want 5", lvl_a);
    end
    fs_a = 1'b1;
    @(negedge clk);
    fs_a = 1'b0;
    n_vec++;
    if (lvl_a !== 5'd0 || bus_a.pix_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fs_flush got lvl=%0d v=%b want 0/0", lvl_a, bus_a.pix_valid);
    end
    base = acc_a.size();
    for (int i = 0; i < 100 && lvl_a == 5'd0; i++) @(negedge clk);
    en_a = 1'b0;
    n_vec++;
    if (acc_a.size() <= base) begin
      n_err++;
      $display("FAIL fs_restart got no read want addr 0");
    end else if (acc_a[base] !== 22'd0) begin
      n_err++;
      $display("FAIL fs_restart got addr %0d want 0", acc_a[base]);
    end
    n_vec++;
    if (lvl_a !== 5'd1 || bus_a.pix_data !== memw(22'd0)) begin
      n_err++;
      $display("FAIL fs_first_pix got lvl=%0d d=%h want 1/%h",
               lvl_a, bus_a.pix_data, memw(22'd0));
    end
  endtask

  task automatic test_push_pop();
    repeat (5) @(negedge clk);
    fs_a = 1'b1;
    @(negedge clk);
    fs_a = 1'b0;
    en_a = 1'b1;
    for (int i = 0; i < 400 && !(lvl_a == 5'd7 && bus_a.rd_ready); i++)
      @(negedge clk);
    n_vec++;
    if (!(lvl_a == 5'd7 && bus_a.rd_ready)) begin
      n_err++;
      $display("FAIL pp_setup got lvl=%0d rdy=%b want 7/1", lvl_a, bus_a.rd_ready);
    end
    bus_a.pix_ready = 1'b1;
    en_a = 1'b0;
    n_vec++;
    if (bus_a.pix_data !== memw(22'd0)) begin
      n_err++;
      $display("FAIL pp_head got %h want %h", bus_a.pix_data, memw(22'd0));
    end
    @(negedge clk);
    bus_a.pix_ready = 1'b0;
    n_vec++;
    if (lvl_a !== 5'd7) begin
      n_err++;
      $display("FAIL pp_level got %0d want 7", lvl_a);
    end
    for (int k = 1; k <= 7; k++) begin
      n_vec++;
      if (bus_a.pix_valid !== 1'b1 || bus_a.pix_data !== memw(22'(k))) begin
        n_err++;
        $display("FAIL pp_order[%0d] got v=%b d=%h want 1/%h",
                 k, bus_a.pix_valid, bus_a.pix_data, memw(22'(k)));
      end
      bus_a.pix_ready = 1'b1;
      @(negedge clk);
      bus_a.pix_ready = 1'b0;
    end
    n_vec++;
    if (lvl_a !== 5'd0) begin
      n_err++;
      $display("FAIL pp_empty got %0d want 0", lvl_a);
    end
  endtask

  task automatic test_wrap();
    int k = 0;
    int nd = 0;
    bus_b.pix_ready = 1'b1;
    en_b = 1'b1;
    for (int i = 0; i < 1000 && k < 12; i++) begin
      @(negedge clk);
      if (done_b) begin
        nd++;
        n_vec++;
        if (bus_b.pix_valid !== 1'b1 || bus_b.pix_data !== memw(22'd3)) begin
          n_err++;
          $display("FAIL wrap_done_pos got v=%b d=%h want 1/%h",
                   bus_b.pix_valid, bus_b.pix_data, memw(22'd3));
        end
      end
      if (bus_b.pix_valid) begin
        n_vec++;
        if (bus_b.pix_data !== memw(22'(k % 4))) begin
          n_err++;
          $display("FAIL wrap_pix[%0d] got %h want %h",
                   k, bus_b.pix_data, memw(22'(k % 4)));
        end
        k++;
      end
    end
    en_b = 1'b0;
    bus_b.pix_ready = 1'b0;
    n_vec++;
    if (k != 12) begin
      n_err++;
      $display("FAIL wrap_count got %0d pixels want 12", k);
    end
    n_vec++;
    if (nd != 3) begin
      n_err++;
      $display("FAIL wrap_frame_done got %0d pulses want 3", nd);
    end
    for (int i = 0; i < 8 && i < acc_b.size(); i++) begin
      n_vec++;
      if (acc_b[i] !== 22'(i % 4)) begin
        n_err++;
        $display("FAIL wrap_addr[%0d] got %0d want %0d", i, acc_b[i], i % 4);
      end
    end
  endtask

  initial begin
    bus_a.pix_ready = 1'b0;
    bus_b.pix_ready = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_refresh();
    test_underrun();
    test_frame_start();
    test_push_pop();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
